// File: rtl/vpipe_pkg.sv
// Shared types for the vector pipe issue controller: opcodes, operand
// source selects, controller states and the shadow-stage record.
package vpipe_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_EX = 2'b01,
    FWD_WB = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [1:0] rd;
  } stage_t;

  // Instruction layout: [7:6] op, [5:4] rs1, [3:2] rs2, [1:0] rd.
  function automatic op_e op_of(input logic [7:0] i);
    return op_e'(i[7:6]);
  endfunction

  function automatic logic [1:0] rs1_of(input logic [7:0] i);
    return i[5:4];
  endfunction

  function automatic logic [1:0] rs2_of(input logic [7:0] i);
    return i[3:2];
  endfunction

  function automatic logic [1:0] rd_of(input logic [7:0] i);
    return i[1:0];
  endfunction

endpackage

// File: rtl/vpipe_scoreboard.sv
// Compares the offered instruction's sources against the EX/WB shadow
// destinations, yielding the RAW stall flag and the operand bypass selects.
module vpipe_scoreboard
  import vpipe_pkg::*;
(
  input  logic [7:0] inst,
  input  logic       fwd_en,
  input  stage_t     ex,
  input  stage_t     wb,
  output logic       hazard,
  output fwd_e       fwd_sel1,
  output fwd_e       fwd_sel2
);

  logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;

  always_comb begin
    ex_hit1 = ex.vld && (ex.rd == rs1_of(inst));
    ex_hit2 = ex.vld && (ex.rd == rs2_of(inst));
    wb_hit1 = wb.vld && (wb.rd == rs1_of(inst));
    wb_hit2 = wb.vld && (wb.rd == rs2_of(inst));

    hazard = !fwd_en && (op_of(inst) != OP_NOP) &&
             (ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2);

    // The younger producer (EX) holds the newest value, so it wins over WB.
    fwd_sel1 = FWD_RF;
    fwd_sel2 = FWD_RF;
    if (fwd_en) begin
      if (ex_hit1)      fwd_sel1 = FWD_EX;
      else if (wb_hit1) fwd_sel1 = FWD_WB;
      if (ex_hit2)      fwd_sel2 = FWD_EX;
      else if (wb_hit2) fwd_sel2 = FWD_WB;
    end
  end

endmodule

// File: rtl/vpipe_issue_ctrl.sv
// Issue controller: tracks EX/WB destinations, stalls or bypasses on RAW
// hazards, and sequences IDLE/RUN/DRAIN for pipeline draining.
module vpipe_issue_ctrl
  import vpipe_pkg::*;
#(
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inst_valid,
  input  logic [7:0]             inst,
  output logic                   inst_ready,
  input  logic                   pipe_ready,
  input  logic                   fwd_en,
  input  logic                   drain_req,
  output logic                   iss_valid,
  output logic [7:0]             iss_inst,
  output logic [1:0]             fwd_sel1,
  output logic [1:0]             fwd_sel2,
  output logic                   drained,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  state_e state, state_nxt;
  stage_t ex, wb;
  logic   hazard, handshake, empty;
  fwd_e   sel1_c, sel2_c;

  vpipe_scoreboard u_scoreboard (
    .inst     (inst),
    .fwd_en   (fwd_en),
    .ex       (ex),
    .wb       (wb),
    .hazard   (hazard),
    .fwd_sel1 (sel1_c),
    .fwd_sel2 (sel2_c)
  );

  assign inst_ready = !rst && pipe_ready && !hazard && (state == ST_RUN);
  assign handshake  = inst_valid && inst_ready;
  assign empty      = !ex.vld && !wb.vld && !iss_valid;
  assign drained    = !rst && (state == ST_DRAIN) && empty;
  assign busy       = ex.vld || wb.vld;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!drain_req) state_nxt = ST_RUN;
      ST_RUN:   if (drain_req)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (empty)      state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Shadow stages and issue outputs all freeze together while pipe_ready=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex        <= '0;
      wb        <= '0;
      iss_valid <= 1'b0;
      iss_inst  <= '0;
      fwd_sel1  <= FWD_RF;
      fwd_sel2  <= FWD_RF;
    end else if (pipe_ready) begin
      wb        <= ex;
      ex        <= '{vld: handshake && (op_of(inst) != OP_NOP), rd: rd_of(inst)};
      iss_valid <= handshake;
      if (handshake) begin
        iss_inst <= inst;
        fwd_sel1 <= sel1_c;
        fwd_sel2 <= sel2_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (inst_valid && pipe_ready && hazard && (state == ST_RUN) &&
                 (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vpipe_issue_ctrl.sv
// Directed bench for vpipe_issue_ctrl: a vector table for bypass/stall
// behaviour plus hand-written freeze, drain, reset and saturation sequences.
module tb_vpipe_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       inst_valid;
  logic [7:0] inst;
  logic       inst_ready;
  logic       pipe_ready;
  logic       fwd_en;
  logic       drain_req;
  logic       iss_valid;
  logic [7:0] iss_inst;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic       drained;
  logic       busy;
  logic [7:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [7:0] i;
    logic       pr, fe, dr;
    logic       rdy;
    logic       iv;
    logic [7:0] ii;
    logic [1:0] s1, s2;
    logic       bz;
    logic [7:0] st;
  } vec_t;

  vec_t tbl[19];

  always #5 clk = ~clk;

  vpipe_issue_ctrl #(.STALL_CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .pipe_ready (pipe_ready),
    .fwd_en     (fwd_en),
    .drain_req  (drain_req),
    .iss_valid  (iss_valid),
    .iss_inst   (iss_inst),
    .fwd_sel1   (fwd_sel1),
    .fwd_sel2   (fwd_sel2),
    .drained    (drained),
    .busy       (busy),
    .stall_cnt  (stall_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives inputs just after an edge and settles to just before the next one.
  task automatic applyStimulus(input logic v, input logic [7:0] i,
                               input logic pr, input logic fe, input logic dr);
    inst_valid = v;
    inst       = i;
    pipe_ready = pr;
    fwd_en     = fe;
    drain_req  = dr;
    #3;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_iss_valid"}, iss_valid, 0);
    checkOutput({tag, "_iss_inst"},  iss_inst,  0);
    checkOutput({tag, "_sel1"},      fwd_sel1,  0);
    checkOutput({tag, "_sel2"},      fwd_sel2,  0);
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_stall"},     stall_cnt, 0);
    checkOutput({tag, "_drained"},   drained,   0);
    checkOutput({tag, "_ready"},     inst_ready, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1, 8'h9B, 1, 1, 0);
    checkOutput("rst_ready_now", inst_ready, 0);
    tick();
    tick();
    checkResetValues("rst");
    rst = 1'b0;
    inst_valid = 1'b0;
  endtask

  task automatic issueInst(input logic [7:0] i, input logic fe);
    int n;
    n = 0;
    applyStimulus(1, i, 1, fe, 0);
    while (!inst_ready && n < 8) begin
      tick();
      #3;
      n++;
    end
    checkOutput("issue_accepted", inst_ready, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst = 8'h00;
    pipe_ready = 1'b0; fwd_en = 1'b0; drain_req = 1'b0;

    //           v  inst    pr fe dr  rdy iv ii     s1 s2 bz st
    tbl[0]  = '{0, 8'h00, 1, 1, 0,  0, 0, 8'h00, 0, 0, 0, 0};
    tbl[1]  = '{1, 8'h9B, 1, 1, 0,  1, 1, 8'h9B, 0, 0, 1, 0};
    tbl[2]  = '{1, 8'h7C, 1, 1, 0,  1, 1, 8'h7C, 1, 1, 1, 0};
    tbl[3]  = '{0, 8'h00, 1, 1, 0,  1, 0, 8'h7C, 1, 1, 1, 0};
    tbl[4]  = '{0, 8'h00, 1, 1, 0,  1, 0, 8'h7C, 1, 1, 0, 0};
    tbl[5]  = '{1, 8'h9B, 1, 0, 0,  1, 1, 8'h9B, 0, 0, 1, 0};
    tbl[6]  = '{1, 8'h7C, 1, 0, 0,  0, 0, 8'h9B, 0, 0, 1, 1};
    tbl[7]  = '{1, 8'h7C, 1, 0, 0,  0, 0, 8'h9B, 0, 0, 0, 2};
    tbl[8]  = '{1, 8'h7C, 1, 0, 0,  1, 1, 8'h7C, 0, 0, 1, 2};
    tbl[9]  = '{0, 8'h00, 1, 0, 0,  1, 0, 8'h7C, 0, 0, 1, 2};
    tbl[10] = '{0, 8'h00, 1, 0, 0,  1, 0, 8'h7C, 0, 0, 0, 2};
    tbl[11] = '{1, 8'h56, 1, 1, 0,  1, 1, 8'h56, 0, 0, 1, 2};
    tbl[12] = '{1, 8'h00, 1, 1, 0,  1, 1, 8'h00, 0, 0, 1, 2};
    tbl[13] = '{1, 8'hE1, 1, 1, 0,  1, 1, 8'hE1, 2, 0, 1, 2};
    tbl[14] = '{0, 8'h00, 1, 1, 0,  1, 0, 8'hE1, 2, 0, 1, 2};
    tbl[15] = '{0, 8'h00, 1, 1, 0,  1, 0, 8'hE1, 2, 0, 0, 2};
    tbl[16] = '{1, 8'h55, 1, 0, 0,  1, 1, 8'h55, 0, 0, 1, 2};
    tbl[17] = '{1, 8'h14, 1, 0, 0,  1, 1, 8'h14, 0, 0, 1, 2};
    tbl[18] = '{0, 8'h00, 1, 0, 0,  1, 0, 8'h14, 0, 0, 0, 2};

    doReset();

    for (int k = 0; k < 19; k++) begin
      applyStimulus(tbl[k].v, tbl[k].i, tbl[k].pr, tbl[k].fe, tbl[k].dr);
      checkOutput($sformatf("row%0d_ready", k), inst_ready, tbl[k].rdy);
      tick();
      checkOutput($sformatf("row%0d_iss_valid", k), iss_valid, tbl[k].iv);
      if (tbl[k].iv) begin
        checkOutput($sformatf("row%0d_iss_inst", k), iss_inst, tbl[k].ii);
        checkOutput($sformatf("row%0d_sel1", k), fwd_sel1, tbl[k].s1);
        checkOutput($sformatf("row%0d_sel2", k), fwd_sel2, tbl[k].s2);
      end
      checkOutput($sformatf("row%0d_busy", k), busy, tbl[k].bz);
      checkOutput($sformatf("row%0d_stall", k), stall_cnt, tbl[k].st);
    end

    // Freeze for three cycles with a dependent ADD waiting behind a SUB.
    applyStimulus(1, 8'h9B, 1, 1, 0);
    checkOutput("frz_ready_first", inst_ready, 1);
    tick();
    checkOutput("frz_iss_first", iss_inst, 8'h9B);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 8'h7C, 0, 1, 0);
      checkOutput("frz_ready", inst_ready, 0);
      tick();
      checkOutput("frz_valid", iss_valid, 1);
      checkOutput("frz_inst", iss_inst, 8'h9B);
      checkOutput("frz_sel1", fwd_sel1, 0);
      checkOutput("frz_busy", busy, 1);
    end
    applyStimulus(1, 8'h7C, 1, 1, 0);
    checkOutput("frz_ready_resume", inst_ready, 1);
    tick();
    checkOutput("frz_valid_resume", iss_valid, 1);
    checkOutput("frz_inst_resume", iss_inst, 8'h7C);
    checkOutput("frz_sel1_resume", fwd_sel1, 1);
    checkOutput("frz_sel2_resume", fwd_sel2, 1);
    applyStimulus(0, 8'h00, 1, 1, 0);
    tick();
    checkOutput("frz_no_double", iss_valid, 0);
    tick();
    tick();

    // Drain with two instructions in flight.
    applyStimulus(1, 8'h56, 1, 1, 0);
    tick();
    applyStimulus(1, 8'h9B, 1, 1, 0);
    tick();
    applyStimulus(0, 8'h00, 1, 1, 1);
    checkOutput("drn_busy_at_req", busy, 1);
    checkOutput("drn_drained_at_req", drained, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k < 3, 8'hE1, 1, 1, 0);
      checkOutput($sformatf("drn%0d_ready", k), inst_ready, k == 3);
      checkOutput($sformatf("drn%0d_drained", k), drained, k == 1);
      tick();
      checkOutput($sformatf("drn%0d_no_issue", k), iss_valid, 0);
    end

    // Drain requested on the same cycle as a handshake.
    applyStimulus(1, 8'h56, 1, 1, 1);
    checkOutput("drnhs_ready", inst_ready, 1);
    tick();
    checkOutput("drnhs_iss_valid", iss_valid, 1);
    checkOutput("drnhs_iss_inst", iss_inst, 8'h56);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 8'h00, 1, 1, 0);
      checkOutput($sformatf("drnhs%0d_drained", k), drained, k == 2);
      checkOutput($sformatf("drnhs%0d_ready", k), inst_ready, k == 4);
      tick();
    end

    // Drain requested while the pipe is frozen.
    applyStimulus(1, 8'h56, 1, 1, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 1, 1);
    checkOutput("drnfz_req_ready", inst_ready, 0);
    checkOutput("drnfz_req_drained", drained, 0);
    tick();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 8'h00, k >= 2, 1, 0);
      checkOutput($sformatf("drnfz%0d_drained", k), drained, k == 4);
      checkOutput($sformatf("drnfz%0d_ready", k), inst_ready, k == 6);
      tick();
      if (k < 3) checkOutput($sformatf("drnfz%0d_iss_valid", k), iss_valid, k < 2);
    end

    // Reset asserted while draining.
    applyStimulus(1, 8'h56, 1, 1, 0);
    tick();
    applyStimulus(1, 8'h9B, 1, 1, 0);
    tick();
    applyStimulus(0, 8'h00, 1, 1, 1);
    tick();
    rst = 1'b1;
    applyStimulus(1, 8'h9B, 1, 1, 0);
    checkOutput("rstd_drained_pre", drained, 0);
    tick();
    checkResetValues("rstd");
    rst = 1'b0;
    applyStimulus(0, 8'h00, 1, 1, 0);
    checkOutput("rstd_idle_ready", inst_ready, 0);
    checkOutput("rstd_idle_drained", drained, 0);
    tick();
    applyStimulus(0, 8'h00, 1, 1, 0);
    checkOutput("rstd_run_ready", inst_ready, 1);
    checkOutput("rstd_run_drained", drained, 0);
    tick();

    // Stall counter saturation: each SUB/ADD pair costs two stall cycles.
    for (int p = 0; p < 130; p++) begin
      issueInst(8'h9B, 0);
      issueInst(8'h7C, 0);
      if (p == 0)   checkOutput("sat_first_pair", stall_cnt, 2);
      if (p == 126) checkOutput("sat_254", stall_cnt, 254);
      if (p == 127) checkOutput("sat_255", stall_cnt, 255);
    end
    checkOutput("sat_hold", stall_cnt, 255);
    inst_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
